// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned FRAME_LEN     = 5;
  localparam logic [7:0]  ERRCNT_ADDR   = 8'hFF;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    ADDR = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CSUM = 3'd4
  } state_e;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / register-write-out bundle for uart_cmd_parser.
// UART_CMD_ERRCNT_EN adds the err_count signal.
interface uart_cmd_parser_if;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic        parser_busy;
`ifdef UART_CMD_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  // Upstream side: the UART receiver (or a bench) feeding bytes in
  modport master (
    output rx_done, rx_data,
    input  wr_en, wr_addr, wr_data, frame_err, parser_busy
`ifdef UART_CMD_ERRCNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  rx_done, rx_data,
    output wr_en, wr_addr, wr_data, frame_err, parser_busy
`ifdef UART_CMD_ERRCNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Loadable inter-byte down-counter; expired while the count sits at zero.
module uart_cmd_timeout #(
  parameter int unsigned        TO_W    = 16,
  parameter logic [TO_W-1:0]    TIMEOUT = TO_W'(50000)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired_c
);

  logic [TO_W-1:0] r_cnt;

  // Load has priority so a byte arriving at zero restarts the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= TIMEOUT;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TO_W'(1);
    end
  end

  assign o_expired_c = (r_cnt == '0);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte SYNC/ADDR/DHI/DLO/CSUM frames into register-write strobes.
// UART_CMD_ERRCNT_EN adds a saturating frame-error counter on err_count.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]      SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned     TO_W      = 16,
  parameter logic [TO_W-1:0] TIMEOUT   = TO_W'(50000)
) (
  input logic               clk,
  input logic               rst_n,
  uart_cmd_parser_if.slave  bus
);

  state_e      r_state, w_next;
  logic [7:0]  r_addr, r_dhi, r_dlo, r_sum;
  logic        r_wr_en, r_frame_err;
  logic [7:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic        w_load, w_wr_set, w_err_set, w_expired;

  uart_cmd_timeout #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_en        (r_state != HUNT),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_next;
  end

  // A received byte always beats a simultaneous timer expiry
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_wr_set  = 1'b0;
    w_err_set = 1'b0;
    if (bus.rx_done) begin
      case (r_state)
        HUNT:    if (bus.rx_data == SYNC_BYTE) w_next = ADDR;
        ADDR:    w_next = DHI;
        DHI:     w_next = DLO;
        DLO:     w_next = CSUM;
        CSUM: begin
          w_next = HUNT;
          if (bus.rx_data == r_sum) w_wr_set  = 1'b1;
          else                      w_err_set = 1'b1;
        end
        default: w_next = HUNT;
      endcase
      w_load = (w_next != HUNT);
    end else if ((r_state != HUNT) && w_expired) begin
      w_next    = HUNT;
      w_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_dhi       <= '0;
      r_dlo       <= '0;
      r_sum       <= '0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_en     <= w_wr_set;
      r_frame_err <= w_err_set;
      if (bus.rx_done) begin
        case (r_state)
          HUNT: r_sum <= '0;
          ADDR: begin r_addr <= bus.rx_data; r_sum <= bus.rx_data;         end
          DHI:  begin r_dhi  <= bus.rx_data; r_sum <= r_sum + bus.rx_data; end
          DLO:  begin r_dlo  <= bus.rx_data; r_sum <= r_sum + bus.rx_data; end
          default: ;
        endcase
      end
      if (w_wr_set) begin
        r_wr_addr <= r_addr;
        r_wr_data <= {r_dhi, r_dlo};
      end
    end
  end

`ifdef UART_CMD_ERRCNT_EN
  logic [7:0] r_err_count;

  // A write to ERRCNT_ADDR clears; errors saturate at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_wr_set && (r_addr == ERRCNT_ADDR)) begin
      r_err_count <= '0;
    end else if (w_err_set && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.err_count = r_err_count;
`endif

  assign bus.wr_en       = r_wr_en;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data     = r_wr_data;
  assign bus.frame_err   = r_frame_err;
  assign bus.parser_busy = (r_state != HUNT);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser; define UART_CMD_ERRCNT_EN
// to also exercise the error counter.
module tb_uart_cmd_parser;

  localparam int unsigned TO = 40;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_err_seen;
  int   e0;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .SYNC_BYTE (8'hA5),
    .TO_W      (16),
    .TIMEOUT   (16'(TO))
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts frame_err pulses; lags the visible pulse by one cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            n_err_seen <= 0;
    else if (bus.frame_err) n_err_seen <= n_err_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(hi);
    send_byte(lo);
    send_byte(cs);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    idle(3);
    check_eq("rst_wr_en",   32'(bus.wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check_eq("rst_err",     32'(bus.frame_err), 32'd0);
    check_eq("rst_busy",    32'(bus.parser_busy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    check_eq("good_busy",    32'(bus.parser_busy), 32'd1);
    send_byte(8'h9C);
    check_eq("good_wr_en",   32'(bus.wr_en), 32'd1);
    check_eq("good_wr_addr", 32'(bus.wr_addr), 32'h12);
    check_eq("good_wr_data", 32'(bus.wr_data), 32'h3456);
    check_eq("good_err",     32'(bus.frame_err), 32'd0);
    idle(1);
    check_eq("good_wr_pulse", 32'(bus.wr_en), 32'd0);
    check_eq("good_idle",     32'(bus.parser_busy), 32'd0);

    // Bad checksum
    send_frame(8'h12, 8'h34, 8'h56, 8'h9D);
    check_eq("bad_err",     32'(bus.frame_err), 32'd1);
    check_eq("bad_wr_en",   32'(bus.wr_en), 32'd0);
    check_eq("bad_wr_addr", 32'(bus.wr_addr), 32'h12);
    check_eq("bad_wr_data", 32'(bus.wr_data), 32'h3456);
    check_eq("bad_busy",    32'(bus.parser_busy), 32'd0);
    idle(1);
    check_eq("bad_err_pulse", 32'(bus.frame_err), 32'd0);

    // Garbage before a frame
    idle(1);
    e0 = n_err_seen;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    check_eq("garb_busy", 32'(bus.parser_busy), 32'd0);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03);
    check_eq("garb_wr_en",   32'(bus.wr_en), 32'd1);
    check_eq("garb_wr_addr", 32'(bus.wr_addr), 32'h01);
    check_eq("garb_wr_data", 32'(bus.wr_data), 32'h0002);
    idle(2);
    check_eq("garb_no_err", 32'(n_err_seen - e0), 32'd0);

    // Inter-byte timeout
    e0 = n_err_seen;
    send_byte(8'hA5); send_byte(8'h12);
    idle(TO + 2);
    check_eq("to_err_once", 32'(n_err_seen - e0), 32'd1);
    check_eq("to_busy",     32'(bus.parser_busy), 32'd0);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03);
    check_eq("to_next_wr_en", 32'(bus.wr_en), 32'd1);

    // Byte lands on the cycle the timer reaches zero
    idle(2);
    e0 = n_err_seen;
    send_byte(8'hA5);
    idle(TO);
    send_byte(8'h21);
    check_eq("edge_busy", 32'(bus.parser_busy), 32'd1);
    send_byte(8'h43); send_byte(8'h65); send_byte(8'hC9);
    check_eq("edge_wr_en",   32'(bus.wr_en), 32'd1);
    check_eq("edge_wr_addr", 32'(bus.wr_addr), 32'h21);
    check_eq("edge_wr_data", 32'(bus.wr_data), 32'h4365);
    idle(2);
    check_eq("edge_no_err", 32'(n_err_seen - e0), 32'd0);

    // Asynchronous reset mid-frame
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check_eq("mid_rst_wr_data", 32'(bus.wr_data), 32'd0);
    check_eq("mid_rst_busy",    32'(bus.parser_busy), 32'd0);
    check_eq("mid_rst_wr_en",   32'(bus.wr_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_frame(8'h12, 8'h34, 8'h56, 8'h9C);
    check_eq("post_rst_wr_en",   32'(bus.wr_en), 32'd1);
    check_eq("post_rst_wr_addr", 32'(bus.wr_addr), 32'h12);
    check_eq("post_rst_wr_data", 32'(bus.wr_data), 32'h3456);

`ifdef UART_CMD_ERRCNT_EN
    idle(1);
    check_eq("cnt_reset", 32'(bus.err_count), 32'd0);
    for (int i = 0; i < 3; i++) send_frame(8'h00, 8'h00, 8'h00, 8'h01);
    idle(1);
    check_eq("cnt_three", 32'(bus.err_count), 32'd3);
    for (int i = 0; i < 300; i++) send_frame(8'h00, 8'h00, 8'h00, 8'h01);
    idle(1);
    check_eq("cnt_sat", 32'(bus.err_count), 32'hFF);
    send_frame(8'hFF, 8'h00, 8'h00, 8'hFF);
    check_eq("cnt_clr_wr_en",   32'(bus.wr_en), 32'd1);
    check_eq("cnt_clr_wr_addr", 32'(bus.wr_addr), 32'hFF);
    check_eq("cnt_clr",         32'(bus.err_count), 32'd0);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
